// File: rtl/rgb2ycbcr_framer.sv
// RGB to BT.601 limited-range YCbCr converter. Three pipeline stages carry
// line/frame position flags for each pixel alongside the colour data.
module rgb2ycbcr_framer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned H_ACTIVE   = 1280,
  parameter int unsigned V_ACTIVE   = 720
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] r_data,
  input  logic [DATA_WIDTH-1:0] g_data,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic                  data_i_valid,
  input  logic                  frame_restart,
  output logic [DATA_WIDTH-1:0] y_data,
  output logic [DATA_WIDTH-1:0] cb_data,
  output logic [DATA_WIDTH-1:0] cr_data,
  output logic                  data_o_valid,
  output logic                  data_o_sop,
  output logic                  data_o_eop,
  output logic                  data_o_sof
);

  localparam int unsigned IW = DATA_WIDTH + 10;
  localparam int unsigned XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int unsigned O  = 1 << (DATA_WIDTH - 8);

  localparam logic signed [IW-1:0] RND   = IW'(128 * O);
  localparam logic signed [IW-1:0] OFF_Y = IW'(16 * O);
  localparam logic signed [IW-1:0] OFF_C = IW'(128 * O);
  localparam logic signed [IW-1:0] MAXV  = IW'((1 << DATA_WIDTH) - 1);

  // Row-major coefficient matrix: Y, Cb, Cr rows times R, G, B columns.
  localparam int COEF [9] = '{66, 129, 25, -38, -74, 112, 112, -94, -18};

  logic [XW-1:0] x_q, x_d, px;
  logic [YW-1:0] y_q, y_d, py;
  logic          sop_in, eop_in, sof_in;

  logic v1_q, sop1_q, eop1_q, sof1_q;
  logic v2_q, sop2_q, eop2_q, sof2_q;

  logic signed [IW-1:0] comp [3];
  logic signed [IW-1:0] p_d  [9];
  logic signed [IW-1:0] p_q  [9];
  logic signed [IW-1:0] s_d  [3];
  logic signed [IW-1:0] s_q  [3];
  logic signed [IW-1:0] t_y, t_cb, t_cr;

  function automatic logic [DATA_WIDTH-1:0] clamp_px(input logic signed [IW-1:0] v);
    logic [DATA_WIDTH-1:0] res;
    if (v[IW-1])       res = '0;
    else if (v > MAXV) res = '1;
    else               res = v[DATA_WIDTH-1:0];
    return res;
  endfunction

  // Position of the incoming pixel and next counter values; restart forces (0,0).
  always_comb begin
    px = x_q;
    py = y_q;
    x_d = x_q;
    y_d = y_q;
    if (frame_restart) begin
      px = '0;
      py = '0;
    end
    if (data_i_valid) begin
      if (px == XW'(H_ACTIVE - 1)) begin
        x_d = '0;
        y_d = (py == YW'(V_ACTIVE - 1)) ? '0 : py + YW'(1);
      end else begin
        x_d = px + XW'(1);
        y_d = py;
      end
    end else if (frame_restart) begin
      x_d = '0;
      y_d = '0;
    end
    sop_in = data_i_valid && (px == '0);
    eop_in = data_i_valid && (px == XW'(H_ACTIVE - 1));
    sof_in = data_i_valid && (px == '0) && (py == '0);
  end

  // Datapath arithmetic for all three stages.
  always_comb begin
    comp[0] = $signed(IW'(r_data));
    comp[1] = $signed(IW'(g_data));
    comp[2] = $signed(IW'(b_data));
    for (int k = 0; k < 9; k++) begin
      p_d[k] = $signed(IW'(COEF[k])) * comp[k % 3];
    end
    for (int c = 0; c < 3; c++) begin
      s_d[c] = p_q[3*c] + p_q[3*c+1] + p_q[3*c+2] + RND;
    end
    t_y  = (s_q[0] >>> 8) + OFF_Y;
    t_cb = (s_q[1] >>> 8) + OFF_C;
    t_cr = (s_q[2] >>> 8) + OFF_C;
  end

  // Intermediate data registers hold don't-care values while invalid.
  always_ff @(posedge clk) begin
    p_q <= p_d;
    s_q <= s_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q          <= '0;
      y_q          <= '0;
      v1_q         <= 1'b0;
      sop1_q       <= 1'b0;
      eop1_q       <= 1'b0;
      sof1_q       <= 1'b0;
      v2_q         <= 1'b0;
      sop2_q       <= 1'b0;
      eop2_q       <= 1'b0;
      sof2_q       <= 1'b0;
      data_o_valid <= 1'b0;
      data_o_sop   <= 1'b0;
      data_o_eop   <= 1'b0;
      data_o_sof   <= 1'b0;
      y_data       <= '0;
      cb_data      <= '0;
      cr_data      <= '0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      v1_q         <= data_i_valid;
      sop1_q       <= sop_in;
      eop1_q       <= eop_in;
      sof1_q       <= sof_in;
      v2_q         <= v1_q;
      sop2_q       <= sop1_q;
      eop2_q       <= eop1_q;
      sof2_q       <= sof1_q;
      data_o_valid <= v2_q;
      data_o_sop   <= sop2_q;
      data_o_eop   <= eop2_q;
      data_o_sof   <= sof2_q;
      y_data       <= clamp_px(t_y);
      cb_data      <= clamp_px(t_cb);
      cr_data      <= clamp_px(t_cr);
    end
  end

endmodule
